// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port-addressed RAM between two requesters.
// After reset the block zeroes the whole RAM, then serves requests with
// round-robin arbitration. It issues at most one access every two cycles.
// Read data returns 2 cycles after the grant.
// Ports: clk/reset (sync, active-high); req/we/addr/wdata per requester A and B;
//   gnt/rvalid/rdata per requester; busy (clear sweep running);
//   mem_addr/mem_wren/mem_wdata to the RAM, mem_rdata from it (1-cycle registered read).
module ram_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {CLEAR, IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic               last_b_q, last_b_d;   // 1 = B won most recently
  logic               busy_q, busy_d;
  logic               gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic               mem_wren_q, mem_wren_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic               rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic               rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [WIDTH-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic               pick_a, pick_b;

  // Round-robin: on a conflict the requester that did not win last time goes.
  assign pick_a = req_a & (~req_b | last_b_q);
  assign pick_b = req_b & ~pick_a;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    busy_d      = busy_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wren_d  = 1'b0;
    mem_wdata_d = mem_wdata_q;

    // Read return pipeline runs independently of the FSM, so a completing
    // read never stalls arbitration. The RAM answers one cycle after the
    // grant cycle, and the data is captured on the following edge.
    rd_pend_a_d = gnt_a_q & ~mem_wren_q;
    rd_pend_b_d = gnt_b_q & ~mem_wren_q;
    rvalid_a_d  = rd_pend_a_q;
    rvalid_b_d  = rd_pend_b_q;
    rdata_a_d   = rd_pend_a_q ? mem_rdata : rdata_a_q;
    rdata_b_d   = rd_pend_b_q ? mem_rdata : rdata_b_q;

    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          mem_addr_d  = cnt_q + 1'b1;
          mem_wren_d  = 1'b1;
          mem_wdata_d = '0;
        end
      end
      IDLE: begin
        if (pick_a) begin
          state_d     = ISSUE;
          gnt_a_d     = 1'b1;
          last_b_d    = 1'b0;
          mem_addr_d  = addr_a;
          mem_wren_d  = we_a;
          mem_wdata_d = wdata_a;
        end else if (pick_b) begin
          state_d     = ISSUE;
          gnt_b_d     = 1'b1;
          last_b_d    = 1'b1;
          mem_addr_d  = addr_b;
          mem_wren_d  = we_b;
          mem_wdata_d = wdata_b;
        end
      end
      ISSUE: begin
        // Requests are not looked at here; the granted requester may still
        // show req this cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // The sweep's first write (address 0) is already presented while reset is held.
      state_q     <= CLEAR;
      cnt_q       <= '0;
      last_b_q    <= 1'b1;
      busy_q      <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b1;
      mem_wdata_q <= '0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      busy_q      <= busy_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wren  = mem_wren_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, mem_wren;
  logic [31:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.WIDTH(32), .AW(6)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM with registered read port, left uninitialised so only the clear sweep makes it zero.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grants and read returns must be mutually exclusive at all times.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("gnt_excl", {63'd0, gnt_a & gnt_b}, 64'd0);
      chk("rvalid_excl", {63'd0, rvalid_a & rvalid_b}, 64'd0);
    end
  end

  initial begin
    reset = 1'b1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wren", mem_wren, 1);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdata_b", rdata_b, 0);

    // Clear sweep: address 0 already shown, 1..63 follow, 64 busy cycles total.
    reset = 1'b0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      chk("sweep_busy", busy, 1);
      chk("sweep_addr", mem_addr, i);
      chk("sweep_wren", mem_wren, 1);
      chk("sweep_wdata", mem_wdata, 0);
      chk("sweep_no_gnt", gnt_a, 0);
      if (i == 10) begin
        req_a = 1; we_a = 0; addr_a = 7;   // request during CLEAR
      end
    end
    @(negedge clk);  // first IDLE cycle
    chk("idle_busy", busy, 0);
    chk("idle_wren", mem_wren, 0);
    chk("idle_no_gnt", gnt_a, 0);
    @(negedge clk);
    chk("late_gnt_a", gnt_a, 1);
    chk("late_gnt_addr", mem_addr, 7);
    chk("late_gnt_wren", mem_wren, 0);
    req_a = 0;
    @(negedge clk);
    chk("rd7_rvalid_early", rvalid_a, 0);
    @(negedge clk);
    chk("rd7_rvalid", rvalid_a, 1);
    chk("rd7_rdata_cleared", rdata_a, 0);

    // A writes DEADBEEF to 5, then reads it back.
    req_a = 1; we_a = 1; addr_a = 5; wdata_a = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr5_gnt", gnt_a, 1);
    chk("wr5_wren", mem_wren, 1);
    chk("wr5_addr", mem_addr, 5);
    chk("wr5_wdata", mem_wdata, 32'hDEADBEEF);
    we_a = 0;
    @(negedge clk);
    chk("wr5_gap_gnt", gnt_a, 0);
    chk("wr5_gap_wren", mem_wren, 0);
    chk("wr5_no_rvalid", rvalid_a, 0);
    @(negedge clk);
    chk("rd5_gnt", gnt_a, 1);
    chk("rd5_wren", mem_wren, 0);
    chk("rd5_addr", mem_addr, 5);
    req_a = 0;
    @(negedge clk);
    chk("rd5_rvalid_early", rvalid_a, 0);
    @(negedge clk);
    chk("rd5_rvalid", rvalid_a, 1);
    chk("rd5_rdata", rdata_a, 32'hDEADBEEF);

    // B writes 2, then A (read 1) and B (read 2) hold req together.
    req_b = 1; we_b = 1; addr_b = 2; wdata_b = 32'h12345678;
    @(negedge clk);
    chk("wr2_gnt_b", gnt_b, 1);
    chk("wr2_gnt_a", gnt_a, 0);
    chk("wr2_wren", mem_wren, 1);
    chk("wr2_addr", mem_addr, 2);
    chk("wr2_wdata", mem_wdata, 32'h12345678);
    we_b = 0; req_a = 1; we_a = 0; addr_a = 1;
    @(negedge clk);
    chk("rr_gap0", {gnt_a, gnt_b}, 0);
    @(negedge clk);
    chk("rr_gnt1_a", {gnt_a, gnt_b}, 2'b10);
    chk("rr_gnt1_addr", mem_addr, 1);
    @(negedge clk);
    chk("rr_gap1", {gnt_a, gnt_b}, 0);
    @(negedge clk);
    chk("rr_gnt2_b", {gnt_a, gnt_b}, 2'b01);
    chk("rr_gnt2_addr", mem_addr, 2);
    chk("rr_rvalid1_a", rvalid_a, 1);
    chk("rr_rdata1_a", rdata_a, 0);
    @(negedge clk);
    chk("rr_gap2", {gnt_a, gnt_b}, 0);
    @(negedge clk);
    chk("rr_gnt3_a", {gnt_a, gnt_b}, 2'b10);
    chk("rr_rvalid2_b", rvalid_b, 1);
    chk("rr_rdata2_b", rdata_b, 32'h12345678);
    @(negedge clk);
    chk("rr_gap3", {gnt_a, gnt_b}, 0);
    @(negedge clk);
    chk("rr_gnt4_b", {gnt_a, gnt_b}, 2'b01);
    chk("rr_rvalid3_a", rvalid_a, 1);
    req_a = 0; req_b = 0;
    @(negedge clk);
    chk("rr_end_gnt", {gnt_a, gnt_b}, 0);
    chk("rr_end_addr_hold", mem_addr, 2);
    chk("rr_end_wren", mem_wren, 0);
    @(negedge clk);
    chk("rr_end_gnt2", {gnt_a, gnt_b}, 0);
    chk("rr_rvalid4_b", rvalid_b, 1);
    chk("rr_rdata4_b", rdata_b, 32'h12345678);
    chk("rr_rvalid4_a", rvalid_a, 0);

    // Reset in the cycle after a read grant discards the read.
    req_a = 1; we_a = 0; addr_a = 5;
    @(negedge clk);
    chk("inflight_gnt", gnt_a, 1);
    req_a = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("inflight_no_rvalid", rvalid_a, 0);
    chk("inflight_busy", busy, 1);
    chk("inflight_addr", mem_addr, 0);
    chk("inflight_rdata_cleared", rdata_a, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("resweep_busy", busy, 1);
    chk("resweep_addr1", mem_addr, 1);
    repeat (62) @(negedge clk);
    chk("resweep_addr63", mem_addr, 63);
    chk("resweep_busy63", busy, 1);
    @(negedge clk);
    chk("resweep_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
